// File: rtl/onchip_mem_pkg.sv
// Shared types and widths for the on-chip RAM command bridge.
//   ADDR_W  : RAM word-address width (RAM depth = 2**ADDR_W words)
//   DATA_W  : data width, BE_W byte lanes
//   BADDR_W : byte-address width seen by the master
//   cmd_t   : one buffered command {is_write, addr, be, wdata}
//   issue_state_t : issue-side state machine encoding
`timescale 1ns/1ps
package onchip_mem_pkg;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned BADDR_W = ADDR_W + 2;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/onchip_mem_cmd_bridge_if.sv
// Bus bundle between the Nios data master, the bridge and the RAM s1 port.
//   s_* : byte-addressed Avalon-MM slave side (master drives commands)
//   m_* : word-addressed RAM side (bridge drives, RAM returns m_readdata)
// Modports: slave = bridge view, master = environment (master + RAM) view.
`timescale 1ns/1ps
interface onchip_mem_cmd_bridge_if;
  import onchip_mem_pkg::*;

  logic [BADDR_W-1:0] s_address;
  logic               s_read;
  logic               s_write;
  logic [BE_W-1:0]    s_byteenable;
  logic [DATA_W-1:0]  s_writedata;
  logic               s_waitrequest;
  logic [DATA_W-1:0]  s_readdata;
  logic               s_readdatavalid;
  logic               s_misaligned;

  logic [ADDR_W-1:0]  m_address;
  logic [BE_W-1:0]    m_byteenable;
  logic               m_chipselect;
  logic               m_write;
  logic [DATA_W-1:0]  m_writedata;
  logic               m_clken;
  logic [DATA_W-1:0]  m_readdata;

  modport slave (
    input  s_address, s_read, s_write, s_byteenable, s_writedata, m_readdata,
    output s_waitrequest, s_readdata, s_readdatavalid, s_misaligned,
           m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

  modport master (
    output s_address, s_read, s_write, s_byteenable, s_writedata, m_readdata,
    input  s_waitrequest, s_readdata, s_readdatavalid, s_misaligned,
           m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

endinterface

// File: rtl/onchip_mem_cmd_fifo.sv
// Synchronous command FIFO of cmd_t with extra-wrap-bit pointers.
//   clk, rst_n          : clock, async active-low reset (pointers only)
//   i_push / i_din      : write one entry (ignored when full)
//   i_pop               : drop head entry (ignored when empty)
//   o_dout_c            : head entry, combinational from storage
//   o_full_c / o_empty_c / o_count_c : occupancy, combinational from pointers
`timescale 1ns/1ps
module onchip_mem_cmd_fifo
  import onchip_mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  cmd_t             i_din,
  input  logic             i_pop,
  output cmd_t             o_dout_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count_c
);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = CNT_W'(r_wr_ptr - r_rd_ptr);
  assign w_full    = (w_count == CNT_W'(DEPTH));
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
  end

  // Pointer update; MSB is the wrap bit distinguishing full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign o_dout_c  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_full_c  = w_full;
  assign o_empty_c = w_empty;
  assign o_count_c = w_count;

endmodule

// File: rtl/onchip_mem_cmd_bridge.sv
// Avalon-MM pipeline bridge in front of the on-chip RAM s1 port.
// Buffers byte-addressed master commands, issues them in order to the
// word-addressed RAM one per cycle, and returns read data with readdatavalid.
// Issue is suspended (HOLD) while reset_req is high.
//   clk, reset_n : clock, async active-low reset
//   reset_req    : reset-controller early warning, blocks acceptance and issue
//   bus          : onchip_mem_cmd_bridge_if.slave (s_* master side, m_* RAM side)
// Optional macro RESP_REG_EN: registers s_readdata/s_readdatavalid,
// adding one cycle of read latency.
`timescale 1ns/1ps
module onchip_mem_cmd_bridge
  import onchip_mem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   reset_req,
  onchip_mem_cmd_bridge_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  issue_state_t          r_state;
  issue_state_t          w_state_nxt;
  logic                  r_rst_done;
  logic                  r_misaligned;
  logic [RD_LATENCY-1:0] r_rd_pend;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_last;
  logic                  w_wait;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cs;
  logic                  w_rd_issue;
  logic                  w_rvalid;
  cmd_t                  w_cmd_in;
  cmd_t                  w_head;

  // Acceptance side: waitrequest uses the pre-pop full flag.
  assign w_wait = w_full | reset_req | ~r_rst_done;
  assign w_push = (bus.s_read | bus.s_write) & ~w_wait;
  assign w_last = (w_count == CNT_W'(1));

  // Write wins over a simultaneous read; reads carry all byte lanes.
  always_comb begin
    w_cmd_in.is_write = bus.s_write;
    w_cmd_in.addr     = bus.s_address[BADDR_W-1:2];
    w_cmd_in.be       = bus.s_write ? bus.s_byteenable : '1;
    w_cmd_in.wdata    = bus.s_writedata;
  end

  onchip_mem_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_push    (w_push),
    .i_din     (w_cmd_in),
    .i_pop     (w_pop),
    .o_dout_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count_c (w_count)
  );

  // Out-of-reset flag and sticky misaligned-address flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push && (bus.s_address[1:0] != 2'b00)) r_misaligned <= 1'b1;
    end
  end

  // Issue FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Issue FSM: next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty && !reset_req) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (reset_req)                            w_state_nxt = HOLD;
        else if (w_empty || (w_last && !w_push))  w_state_nxt = IDLE;
      end
      HOLD: begin
        if (!reset_req) w_state_nxt = w_empty ? IDLE : ISSUE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Issue FSM: outputs. reset_req gates the pop in the very cycle it rises.
  always_comb begin
    w_pop = 1'b0;
    w_cs  = 1'b0;
    if ((r_state == ISSUE) && !reset_req && !w_empty) begin
      w_pop = 1'b1;
      w_cs  = 1'b1;
    end
  end

  assign w_rd_issue = w_pop & ~w_head.is_write;

  // RAM side driven straight from the FIFO head; zero when not selected.
  assign bus.m_chipselect = w_cs;
  assign bus.m_write      = w_cs & w_head.is_write;
  assign bus.m_address    = w_cs ? w_head.addr : '0;
  assign bus.m_byteenable = w_cs ? w_head.be : '0;
  assign bus.m_writedata  = (w_cs & w_head.is_write) ? w_head.wdata : '0;
  assign bus.m_clken      = r_rst_done & ~reset_req;

  // Pending-read marker, one bit per cycle of RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_pend <= '0;
    else          r_rd_pend <= RD_LATENCY'({r_rd_pend, w_rd_issue});
  end

  assign w_rvalid = r_rd_pend[RD_LATENCY-1];

`ifdef RESP_REG_EN
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  // Registered response stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rvalid ? bus.m_readdata : '0;
    end
  end

  assign bus.s_readdatavalid = r_rvalid;
  assign bus.s_readdata      = r_rdata;
`else
  assign bus.s_readdatavalid = w_rvalid;
  assign bus.s_readdata      = w_rvalid ? bus.m_readdata : '0;
`endif

  assign bus.s_waitrequest = w_wait;
  assign bus.s_misaligned  = r_misaligned;

endmodule

// File: tb/tb_onchip_mem_cmd_bridge.sv
// Self-checking bench for onchip_mem_cmd_bridge with a behavioural RAM
// (registered address, unregistered q, byte lanes, clock enable).
// Expected RAM-side commands and read data are queued by the stimulus;
// two monitors pop and compare when the DUT issues or returns data.
`timescale 1ns/1ps
module tb_onchip_mem_cmd_bridge;
  import onchip_mem_pkg::*;

`ifdef RESP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic reset_req = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   cycle     = 0;

  cmd_t              exp_iss [$];
  logic [DATA_W-1:0] exp_rd  [$];
  int                due_q   [$];

  logic [DATA_W-1:0] ram [4];
  logic [ADDR_W-1:0] ram_raddr;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  onchip_mem_cmd_bridge_if bus_if ();

  onchip_mem_cmd_bridge #(
    .FIFO_DEPTH (2),
    .RD_LATENCY (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reset_req (reset_req),
    .bus       (bus_if)
  );

  // Behavioural single-port RAM.
  initial begin
    for (int i = 0; i < 4; i++) ram[i] = '0;
    ram_raddr = '0;
  end

  always @(posedge clk) begin
    if (bus_if.m_clken && bus_if.m_chipselect) begin
      ram_raddr <= bus_if.m_address;
      if (bus_if.m_write)
        for (int b = 0; b < BE_W; b++)
          if (bus_if.m_byteenable[b])
            ram[bus_if.m_address][8*b +: 8] <= bus_if.m_writedata[8*b +: 8];
    end
  end

  assign bus_if.m_readdata = ram[ram_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic w, input logic [1:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    mk.is_write = w;
    mk.addr     = a;
    mk.be       = be;
    mk.wdata    = d;
  endfunction

  // Issue monitor: every RAM access must match the next expected command.
  always @(negedge clk) begin : iss_mon
    cmd_t e;
    if (reset_n && bus_if.m_chipselect) begin
      if (exp_iss.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got addr %0d write %0d expected none",
                 bus_if.m_address, bus_if.m_write);
      end else begin
        e = exp_iss.pop_front();
        check("iss_write", 32'(bus_if.m_write), 32'(e.is_write));
        check("iss_addr", 32'(bus_if.m_address), 32'(e.addr));
        check("iss_be", 32'(bus_if.m_byteenable), 32'(e.be));
        if (e.is_write) check("iss_wdata", bus_if.m_writedata, e.wdata);
        else            due_q.push_back(cycle + LAT);
      end
    end
  end

  // Response monitor: data and exact return cycle of each read.
  always @(negedge clk) begin : rd_mon
    int due;
    if (reset_n && bus_if.s_readdatavalid) begin
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_readdatavalid: got data 0x%0h expected none",
                 bus_if.s_readdata);
      end else begin
        due = (due_q.size() != 0) ? due_q.pop_front() : -1;
        check("rd_data", bus_if.s_readdata, exp_rd.pop_front());
        check("rd_latency", 32'(cycle), 32'(due));
      end
    end
  end

  // Present one command and hold it until accepted; returns stall cycles.
  task automatic send(input logic rd, input logic wr, input logic [3:0] addr,
                      input logic [3:0] be, input logic [31:0] d, output int stalls);
    stalls = 0;
    bus_if.s_read       = rd;
    bus_if.s_write      = wr;
    bus_if.s_address    = addr;
    bus_if.s_byteenable = be;
    bus_if.s_writedata  = d;
    @(negedge clk);
    while (bus_if.s_waitrequest && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got waitrequest 1 for %0d cycles expected accept", stalls);
    end
    @(posedge clk);
    #1;
    bus_if.s_read  = 1'b0;
    bus_if.s_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_iss.size() != 0 || exp_rd.size() != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d issues %0d reads outstanding expected 0",
               exp_iss.size(), exp_rd.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int first_stall;
    bus_if.s_read       = 1'b0;
    bus_if.s_write      = 1'b0;
    bus_if.s_address    = '0;
    bus_if.s_byteenable = '0;
    bus_if.s_writedata  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", 32'(bus_if.s_waitrequest), 32'd1);
    check("rst_readdatavalid", 32'(bus_if.s_readdatavalid), 32'd0);
    check("rst_readdata", bus_if.s_readdata, 32'd0);
    check("rst_misaligned", 32'(bus_if.s_misaligned), 32'd0);
    check("rst_chipselect", 32'(bus_if.m_chipselect), 32'd0);
    check("rst_write", 32'(bus_if.m_write), 32'd0);
    check("rst_address", 32'(bus_if.m_address), 32'd0);
    check("rst_byteenable", 32'(bus_if.m_byteenable), 32'd0);
    check("rst_writedata", bus_if.m_writedata, 32'd0);
    check("rst_clken", 32'(bus_if.m_clken), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_waitrequest", 32'(bus_if.s_waitrequest), 32'd0);
    check("idle_clken", 32'(bus_if.m_clken), 32'd1);
    check("idle_chipselect", 32'(bus_if.m_chipselect), 32'd0);
    @(posedge clk);
    #1;

    // Write then read the same word.
    exp_iss.push_back(mk(1'b1, 2'd2, 4'hF, 32'hDEADBEEF));
    send(1'b0, 1'b1, 4'h8, 4'hF, 32'hDEADBEEF, st);
    exp_iss.push_back(mk(1'b0, 2'd2, 4'hF, 32'h0));
    exp_rd.push_back(32'hDEADBEEF);
    send(1'b1, 1'b0, 4'h8, 4'h3, 32'h0, st);
    drain();

    // Four back-to-back writes against a two-entry FIFO.
    first_stall = -1;
    for (int i = 0; i < 4; i++) begin
      exp_iss.push_back(mk(1'b1, 2'(i), 4'hF, 32'hA000_0000 + 32'(i)));
      send(1'b0, 1'b1, 4'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), st);
      if (st != 0 && first_stall < 0) first_stall = i;
    end
    check("full_accepts_before_wait", 32'(first_stall), 32'd2);
    drain();

    // Byte lanes merge into one word.
    exp_iss.push_back(mk(1'b1, 2'd3, 4'hF, 32'h11223344));
    send(1'b0, 1'b1, 4'hC, 4'hF, 32'h11223344, st);
    exp_iss.push_back(mk(1'b1, 2'd3, 4'h5, 32'hAABBCCDD));
    send(1'b0, 1'b1, 4'hC, 4'h5, 32'hAABBCCDD, st);
    exp_iss.push_back(mk(1'b0, 2'd3, 4'hF, 32'h0));
    exp_rd.push_back(32'h11BB33DD);
    send(1'b1, 1'b0, 4'hC, 4'hF, 32'h0, st);
    drain();

    // reset_req raised between two queued reads.
    exp_iss.push_back(mk(1'b0, 2'd0, 4'hF, 32'h0));
    exp_rd.push_back(32'hA000_0000);
    send(1'b1, 1'b0, 4'h0, 4'hF, 32'h0, st);
    exp_iss.push_back(mk(1'b0, 2'd1, 4'hF, 32'h0));
    exp_rd.push_back(32'hA000_0001);
    send(1'b1, 1'b0, 4'h4, 4'hF, 32'h0, st);
    @(posedge clk);
    #1 reset_req = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_chipselect", 32'(bus_if.m_chipselect), 32'd0);
      check("hold_clken", 32'(bus_if.m_clken), 32'd0);
      check("hold_waitrequest", 32'(bus_if.s_waitrequest), 32'd1);
      @(posedge clk);
      #1;
    end
    reset_req = 1'b0;
    drain();

    // Misaligned write lands on word 1 and sets the sticky flag.
    @(negedge clk);
    check("misaligned_before", 32'(bus_if.s_misaligned), 32'd0);
    @(posedge clk);
    #1;
    exp_iss.push_back(mk(1'b1, 2'd1, 4'hF, 32'h0000_0055));
    send(1'b0, 1'b1, 4'h5, 4'hF, 32'h0000_0055, st);
    @(negedge clk);
    check("misaligned_after", 32'(bus_if.s_misaligned), 32'd1);
    @(posedge clk);
    #1;

    // Simultaneous read and write: only the write is issued.
    exp_iss.push_back(mk(1'b1, 2'd2, 4'hF, 32'h0000_0077));
    send(1'b1, 1'b1, 4'h8, 4'hF, 32'h0000_0077, st);
    drain();
    exp_iss.push_back(mk(1'b0, 2'd1, 4'hF, 32'h0));
    exp_rd.push_back(32'h0000_0055);
    send(1'b1, 1'b0, 4'h4, 4'hF, 32'h0, st);
    exp_iss.push_back(mk(1'b0, 2'd2, 4'hF, 32'h0));
    exp_rd.push_back(32'h0000_0077);
    send(1'b1, 1'b0, 4'h8, 4'hF, 32'h0, st);
    drain();
    check("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

    // Asynchronous reset clears the sticky flag immediately.
    #2 reset_n = 1'b0;
    #1;
    check("areset_misaligned", 32'(bus_if.s_misaligned), 32'd0);
    check("areset_waitrequest", 32'(bus_if.s_waitrequest), 32'd1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_cmd_bridge.md
Name: onchip_mem_cmd_bridge

Overview:
- Avalon-MM pipeline bridge that sits directly upstream of the on-chip RAM slave (s1 port).
- Accepts byte-addressed read/write commands from the Nios data master side and buffers them in a small command FIFO.
- Issues them to the RAM's word-addressed single-port interface.
- Returns read data with readdatavalid, matching the RAM's fixed read latency.
- Suspends issue cleanly while the reset controller asserts reset_req.

Parameters:
- ADDR_W, 2, RAM word-address width (RAM depth = 2**ADDR_W words)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- FIFO_DEPTH, 2, command FIFO entries (power of two, >= 2)
- RD_LATENCY, 1, RAM read latency in cycles (registered address, unregistered q)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- reset_req  in  1  reset-controller early warning; no new RAM access while high
- s_address  in  ADDR_W+2  byte address from master
- s_read  in  1  read request
- s_write  in  1  write request
- s_byteenable  in  DATA_W/8  byte lanes
- s_writedata  in  DATA_W  write data
- s_waitrequest  out  1  command not accepted this cycle
- s_readdata  out  DATA_W  read response data
- s_readdatavalid  out  1  s_readdata valid this cycle
- s_misaligned  out  1  sticky: accepted command had s_address[1:0] != 0
- m_address  out  ADDR_W  RAM word address
- m_byteenable  out  DATA_W/8  RAM byte lanes
- m_chipselect  out  1  RAM select
- m_write  out  1  RAM write
- m_writedata  out  DATA_W  RAM write data
- m_clken  out  1  RAM clock enable
- m_readdata  in  DATA_W  RAM q

Behaviour:
- Reset values (async, reset_n low):
  - FIFO empty; all pointers 0; pending-read shift register 0; state IDLE.
  - s_waitrequest=1, s_readdatavalid=0, s_readdata=0, s_misaligned=0.
  - m_chipselect=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, m_clken=0.
- After reset release:
  - m_clken=1 whenever reset_req=0.
  - s_waitrequest = FIFO full OR reset_req.
- Command acceptance:
  - A command is accepted when (s_read|s_write) & ~s_waitrequest.
  - s_read and s_write both high in one cycle: the write is taken and the read is dropped.
  - FIFO entry = {is_write, s_address[ADDR_W+1:2], byteenable, writedata}. Reads store byteenable as all-ones.
  - Misaligned accepted command: sets s_misaligned (cleared only by reset); the low two address bits are discarded.
- State machine (issue side):
  - IDLE: FIFO empty, m_chipselect=0. Go to ISSUE when the FIFO is non-empty and reset_req=0.
  - ISSUE: pop one entry per cycle and drive m_* combinationally from the FIFO head (m_chipselect=1, m_write=is_write). Go back to IDLE when the FIFO empties after this pop and no push occurred. Go to HOLD when reset_req rises.
  - HOLD: m_chipselect=0, m_clken=0, no pops, FIFO contents retained. Go back to ISSUE (FIFO non-empty) or IDLE when reset_req falls.
  - reset_req is sampled combinationally: in the cycle it rises, no pop occurs.
- Read return:
  - A RD_LATENCY-bit shift register marks issued reads.
  - A read issued in cycle N gives s_readdatavalid=1 with s_readdata=m_readdata in cycle N+RD_LATENCY. No backpressure.
  - Back-to-back reads produce back-to-back valids.
- FIFO boundaries:
  - Push and pop in the same cycle while full is allowed: the pop frees a slot, but s_waitrequest is still computed from the pre-pop full flag. This is conservative and required.
  - Push and pop while empty: not possible, because issue is from registered contents only (min command latency = 1 cycle from acceptance to m_chipselect).
  - Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty.
- Ordering: strictly in-order. A write followed by a read to the same word returns the new data.
- reset_n asserted mid-operation: FIFO contents and in-flight reads are lost; no readdatavalid is produced for them.

Optional Feature:
- RESP_REG_EN defined:
  - s_readdata and s_readdatavalid are registered.
  - Effective read latency seen by the master = RD_LATENCY+1.
  - The register resets to 0.
- RESP_REG_EN undefined: combinational pass-through, latency RD_LATENCY.

Decomposition:
- Shared package onchip_mem_pkg holds:
  - constant BE_W = DATA_W/8
  - typedef cmd_t {is_write, addr, be, wdata}
  - typedef enum issue_state_t {IDLE, ISSUE, HOLD}
- One sub-module: onchip_mem_cmd_fifo. This is a parameterised synchronous FIFO of cmd_t with full/empty/push/pop and async active-low reset.

Test Plan:
- Reset then idle:
  - reset_n low 3 cycles -> all outputs 0, s_waitrequest=1.
  - After release with reset_req=0 -> s_waitrequest=0, m_clken=1, m_chipselect=0.
- Write/read:
  - Write 0xDEADBEEF to byte addr 0x8 with be=0xF, then read 0x8 -> m_address=2 write, then read.
  - s_readdatavalid exactly 1 cycle after the read issue, with s_readdata=0xDEADBEEF (2 cycles with RESP_REG_EN).
- Full FIFO:
  - Hold s_write for 4 consecutive commands with FIFO_DEPTH=2 -> s_waitrequest asserts after 2 accepted.
  - All 4 are eventually written in order to addrs 0,1,2,3.
- Byte lanes:
  - Write 0x11223344 be=0xF, then 0xAABBCCDD be=0x5 to the same word, then read -> 0x11BB33DD.
- reset_req mid-stream:
  - Queue 2 reads, raise reset_req for 5 cycles before the second issues.
  - During hold: m_chipselect=0, m_clken=0, s_waitrequest=1.
  - After drop: the second read issues and a single readdatavalid is returned.
- Misaligned and simultaneous:
  - Write with address 0x5 -> s_misaligned=1 and the RAM writes word 1.
  - s_read&s_write together -> only a write is issued and no readdatavalid follows.
